lf_spi_cmd_rx: RTL

Configuration-command receiver for the LF FPGA image, sitting directly upstream of the LF mode selector, clock divider and mode modules. It oversamples the ARM's SPI pins (`spck`, `mosi`, `ncs`) in the `pck0` domain and assembles 16-bit command frames. It decodes each frame into the registered `conf_word`, `divisor` and `user_byte1` values that drive major-mode selection, `clk_divider` and the edge-detect threshold. All of its outputs are glitch-free and synchronous to `pck0`.

---
 rtl/lf_spi_pkg.sv | 18 +
 rtl/lf_spi_sync_edge.sv | 42 ++++
 rtl/lf_spi_cmd_rx.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/lf_spi_pkg.sv
// rtl/lf_spi_pkg.sv - opcodes, frame constants and FSM state for the LF SPI command receiver
package lf_spi_pkg;

   localparam logic [3:0] OP_CONF          = 4'b0001;
   localparam logic [3:0] OP_DIV           = 4'b0010;
   localparam logic [3:0] OP_UB1           = 4'b0011;
   localparam logic [7:0] CONF_EDGE_DETECT = 8'h01;

   localparam logic [4:0] BIT_CNT_FULL     = 5'd16;
   localparam logic [4:0] BIT_CNT_SAT      = 5'd17;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      DECODE = 2'd2
   } state_t;

endpackage

// File: rtl/lf_spi_sync_edge.sv
// rtl/lf_spi_sync_edge.sv - 2-flop synchroniser with registered rise/fall detect
module lf_spi_sync_edge #(
   parameter logic RST_LVL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_rise,
   output logic o_fall
);

   logic       r_s1;
   logic       r_s2;
   logic       r_s3;
   logic [2:0] r_vld;
   logic       r_rise;
   logic       r_fall;

   // r_vld masks edges until r_s3 holds a real sample, so a pin already at the
   // non-idle level when reset releases is not mistaken for an edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1   <= RST_LVL;
         r_s2   <= RST_LVL;
         r_s3   <= RST_LVL;
         r_vld  <= 3'b000;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_s1   <= i_d;
         r_s2   <= r_s1;
         r_s3   <= r_s2;
         r_vld  <= {r_vld[1:0], 1'b1};
         r_rise <= r_vld[2] &  r_s2 & ~r_s3;
         r_fall <= r_vld[2] & ~r_s2 &  r_s3;
      end
   end

   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule

// File: rtl/lf_spi_cmd_rx.sv
// rtl/lf_spi_cmd_rx.sv - SPI command frame receiver/decoder for the LF image
// Optional miso readback of status/conf_word is enabled by LF_SPI_READBACK_EN.
module lf_spi_cmd_rx
   import lf_spi_pkg::*;
#(
   parameter logic [7:0] DIV_RST = 8'd95,
   parameter logic [7:0] THR_RST = 8'd127
) (
   input  logic       pck0,
   input  logic       nrst,
   input  logic       spck,
   input  logic       mosi,
   input  logic       ncs,
   output logic       miso,
   output logic [7:0] conf_word,
   output logic [7:0] divisor,
   output logic [7:0] user_byte1,
   output logic       cmd_stb,
   output logic       frame_err
);

   logic        w_spck_rise;
   logic        w_spck_fall;
   logic        w_ncs_rise;
   logic        w_ncs_fall;
   logic        r_mosi_s1;
   logic        r_mosi_s2;
   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_shift;
   logic [4:0]  r_bit_cnt;
   logic [7:0]  r_conf_word;
   logic [7:0]  r_divisor;
   logic [7:0]  r_user_byte1;
   logic        r_cmd_stb;
   logic        r_frame_err;
   logic [3:0]  w_unused_mid;

   lf_spi_sync_edge #(.RST_LVL(1'b0)) u_sync_spck (
      .i_clk   (pck0),
      .i_rst_n (nrst),
      .i_d     (spck),
      .o_rise  (w_spck_rise),
      .o_fall  (w_spck_fall)
   );

   lf_spi_sync_edge #(.RST_LVL(1'b1)) u_sync_ncs (
      .i_clk   (pck0),
      .i_rst_n (nrst),
      .i_d     (ncs),
      .o_rise  (w_ncs_rise),
      .o_fall  (w_ncs_fall)
   );

   always_ff @(posedge pck0 or negedge nrst) begin
      if (!nrst) begin
         r_mosi_s1 <= 1'b0;
         r_mosi_s2 <= 1'b0;
      end else begin
         r_mosi_s1 <= mosi;
         r_mosi_s2 <= r_mosi_s1;
      end
   end

   always_ff @(posedge pck0 or negedge nrst) begin
      if (!nrst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_ncs_fall) w_next = SHIFT;
         SHIFT:   if (w_ncs_rise) w_next = DECODE;
         DECODE:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // A bit arriving with the ncs rise is still shifted; DECODE sees the updated count.
   always_ff @(posedge pck0 or negedge nrst) begin
      if (!nrst) begin
         r_shift      <= 16'h0000;
         r_bit_cnt    <= 5'd0;
         r_conf_word  <= 8'h00;
         r_divisor    <= DIV_RST;
         r_user_byte1 <= THR_RST;
         r_cmd_stb    <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_cmd_stb   <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_ncs_fall) begin
                  r_shift   <= 16'h0000;
                  r_bit_cnt <= 5'd0;
               end
            end
            SHIFT: begin
               if (w_spck_rise) begin
                  r_shift <= {r_shift[14:0], r_mosi_s2};
                  if (r_bit_cnt != BIT_CNT_SAT) r_bit_cnt <= r_bit_cnt + 5'd1;
               end
            end
            DECODE: begin
               if (r_bit_cnt == BIT_CNT_FULL) begin
                  r_cmd_stb <= 1'b1;
                  case (r_shift[15:12])
                     OP_CONF: begin
                        r_conf_word <= r_shift[7:0];
                        if (r_shift[7:0] == CONF_EDGE_DETECT) r_user_byte1 <= THR_RST;
                     end
                     OP_DIV:  r_divisor    <= r_shift[7:0];
                     OP_UB1:  r_user_byte1 <= r_shift[7:0];
                     default: ;
                  endcase
               end else begin
                  r_frame_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign w_unused_mid = r_shift[11:8];

`ifdef LF_SPI_READBACK_EN
   logic [15:0] r_rb;
   logic [3:0]  r_err_cnt;

   always_ff @(posedge pck0 or negedge nrst) begin
      if (!nrst) begin
         r_rb      <= 16'h0000;
         r_err_cnt <= 4'd0;
      end else begin
         case (r_state)
            IDLE:    if (w_ncs_fall) r_rb <= {4'b0001, r_err_cnt, r_conf_word};
            SHIFT:   if (w_spck_fall) r_rb <= {r_rb[14:0], 1'b0};
            DECODE: begin
               r_rb <= 16'h0000;
               if (r_bit_cnt != BIT_CNT_FULL) r_err_cnt <= r_err_cnt + 4'd1;
            end
            default: ;
         endcase
      end
   end

   assign miso = r_rb[15];
`else
   logic w_unused_fall;

   assign w_unused_fall = w_spck_fall;
   assign miso          = 1'b0;
`endif

   assign conf_word  = r_conf_word;
   assign divisor    = r_divisor;
   assign user_byte1 = r_user_byte1;
   assign cmd_stb    = r_cmd_stb;
   assign frame_err  = r_frame_err;

endmodule
